// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data memory between the CPU data port and
//            a DMA/loader port. Combinational fixed-priority grant (CPU first)
//            with a starvation counter that forces a DMA grant. The winning
//            command is registered onto the dmem bus, and a {valid, owner} tag
//            pipeline steers read data back to the requester that issued it.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int READ_LAT     = 1,   // command-to-data latency of dmem (1..4)
    parameter int STARVE_LIMIT = 4    // CPU wins while DMA waits (1..15)
) (
    input  logic        clk,
    input  logic        reset,        // synchronous, active low

    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [31:0] cpuAddr,
    input  logic [31:0] cpuWData,
    output logic        cpuGnt,
    output logic        cpuRValid,
    output logic [31:0] cpuRData,

    input  logic        dmaReq,
    input  logic        dmaWe,
    input  logic [31:0] dmaAddr,
    input  logic [31:0] dmaWData,
    output logic        dmaGnt,
    output logic        dmaRValid,
    output logic [31:0] dmaRData,

    output logic [31:0] memAddr,
    output logic [31:0] memWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] memReadData
);

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic        w_starved;
    logic        w_cpuGnt;
    logic        w_dmaGnt;
    logic        w_retValid;
    logic        w_retOwner;

    logic [3:0]  r_starveCnt;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWData;
    logic        r_memWrite;
    logic        r_memRead;
    logic        r_owner;                 // 0 = CPU, 1 = DMA

    logic [READ_LAT-1:0] r_tagValid;
    logic [READ_LAT-1:0] r_tagOwner;

    // Grant decision: CPU has priority unless the DMA has waited too long.
    always_comb begin
        w_starved = dmaReq && (r_starveCnt == c_STARVE_LIMIT);
        w_cpuGnt  = reset && cpuReq && !w_starved;
        w_dmaGnt  = reset && dmaReq && (!cpuReq || w_starved);
    end

    // Starvation counter: counts CPU wins while the DMA is left waiting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starveCnt <= 4'd0;
        end else if (!dmaReq || w_dmaGnt) begin
            r_starveCnt <= 4'd0;
        end else if (w_cpuGnt && (r_starveCnt != c_STARVE_LIMIT)) begin
            r_starveCnt <= r_starveCnt + 4'd1;
        end
    end

    // Command register: the winner's fields drive the dmem bus next cycle;
    // address and write data hold while idle so the bus does not toggle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_memAddr  <= 32'd0;
            r_memWData <= 32'd0;
            r_memWrite <= 1'b0;
            r_memRead  <= 1'b0;
            r_owner    <= 1'b0;
        end else if (w_cpuGnt) begin
            r_memAddr  <= cpuAddr;
            r_memWData <= cpuWData;
            r_memWrite <= cpuWe;
            r_memRead  <= !cpuWe;
            r_owner    <= 1'b0;
        end else if (w_dmaGnt) begin
            r_memAddr  <= dmaAddr;
            r_memWData <= dmaWData;
            r_memWrite <= dmaWe;
            r_memRead  <= !dmaWe;
            r_owner    <= 1'b1;
        end else begin
            r_memWrite <= 1'b0;
            r_memRead  <= 1'b0;
        end
    end

    // Tag pipeline head: records whether the command on the bus is a read
    // and who issued it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tagValid[0] <= 1'b0;
            r_tagOwner[0] <= 1'b0;
        end else begin
            r_tagValid[0] <= r_memRead;
            r_tagOwner[0] <= r_owner;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < READ_LAT; gi++) begin : g_tag_stage
            // Remaining tag stages delay the tag to match dmem read latency.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_tagValid[gi] <= 1'b0;
                    r_tagOwner[gi] <= 1'b0;
                end else begin
                    r_tagValid[gi] <= r_tagValid[gi-1];
                    r_tagOwner[gi] <= r_tagOwner[gi-1];
                end
            end
        end
    endgenerate

    // Return steering: the pipeline tail tells whose data is on memReadData.
    always_comb begin
        w_retValid = reset && r_tagValid[READ_LAT-1];
        w_retOwner = r_tagOwner[READ_LAT-1];
        cpuRValid  = w_retValid && !w_retOwner;
        dmaRValid  = w_retValid &&  w_retOwner;
        cpuRData   = cpuRValid ? memReadData : 32'd0;
        dmaRData   = dmaRValid ? memReadData : 32'd0;
    end

    assign cpuGnt       = w_cpuGnt;
    assign dmaGnt       = w_dmaGnt;
    assign memAddr      = r_memAddr;
    assign memWriteData = r_memWData;
    assign MemWrite     = r_memWrite;
    assign MemRead      = r_memRead;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: directed scenarios followed
//            by randomized traffic, compared against a transaction-level model
//            (grant rule, shadow memory, queue of expected read returns).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int LAT   = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuReq, cpuWe, dmaReq, dmaWe;
    logic [31:0] cpuAddr, cpuWData, dmaAddr, dmaWData;
    logic        cpuGnt, cpuRValid, dmaGnt, dmaRValid;
    logic [31:0] cpuRData, dmaRData;
    logic [31:0] memAddr, memWriteData, memReadData;
    logic        MemWrite, MemRead;

    always #5 clk = ~clk;

    dmem_arbiter #(.READ_LAT(LAT), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk(clk), .reset(reset),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
        .cpuGnt(cpuGnt), .cpuRValid(cpuRValid), .cpuRData(cpuRData),
        .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWData(dmaWData),
        .dmaGnt(dmaGnt), .dmaRValid(dmaRValid), .dmaRData(dmaRData),
        .memAddr(memAddr), .memWriteData(memWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .memReadData(memReadData)
    );

    // ---------------- dmem environment (16 words, LAT-cycle read) ----------
    logic [31:0] dmem [16];
    logic [31:0] rd_dly [LAT];

    always @(posedge clk) begin
        if (MemWrite) dmem[memAddr[5:2]] <= memWriteData;
        rd_dly[0] <= dmem[memAddr[5:2]];
        for (int i = 1; i < LAT; i++) rd_dly[i] <= rd_dly[i-1];
    end
    assign memReadData = rd_dly[LAT-1];

    // ---------------- reference model ---------------------------------------
    typedef struct {
        int          due;
        bit          owner;   // 0 = CPU, 1 = DMA
        logic [31:0] data;
    } ret_t;

    ret_t        ret_q[$];
    logic [31:0] ref_mem [16];
    int          m_starve;
    logic [31:0] e_addr, e_wd;
    logic        e_wr, e_rd;
    logic        g_c, g_d;     // model grants of the last completed cycle
    int          cyc;
    int          n_chk, n_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, act, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance it.
    task automatic step();
        logic ec, ed, ev_c, ev_d;
        logic [31:0] ev_data;
        @(negedge clk);
        if (!reset) begin
            ec = 1'b0; ed = 1'b0;
        end else begin
            ec = cpuReq && !(dmaReq && m_starve == LIMIT);
            ed = dmaReq && !ec;
        end
        chk("cpuGnt", 32'(cpuGnt), 32'(ec));
        chk("dmaGnt", 32'(dmaGnt), 32'(ed));
        chk("MemRead", 32'(MemRead), 32'(e_rd));
        chk("MemWrite", 32'(MemWrite), 32'(e_wr));
        chk("memAddr", memAddr, e_addr);
        chk("memWriteData", memWriteData, e_wd);

        ev_c = 1'b0; ev_d = 1'b0; ev_data = 32'd0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            if (reset) begin
                if (ret_q[0].owner) ev_d = 1'b1; else ev_c = 1'b1;
                ev_data = ret_q[0].data;
            end
            void'(ret_q.pop_front());
        end
        chk("cpuRValid", 32'(cpuRValid), 32'(ev_c));
        chk("dmaRValid", 32'(dmaRValid), 32'(ev_d));
        if (ev_c) chk("cpuRData", cpuRData, ev_data);
        if (ev_d) chk("dmaRData", dmaRData, ev_data);

        // advance the model to the next cycle
        if (!reset) begin
            m_starve = 0;
            e_addr = 32'd0; e_wd = 32'd0; e_wr = 1'b0; e_rd = 1'b0;
            ret_q.delete();
        end else begin
            if (!dmaReq || ed) m_starve = 0;
            else if (ec && m_starve < LIMIT) m_starve++;
            e_wr = 1'b0; e_rd = 1'b0;
            if (ec || ed) begin
                ret_t r;
                logic        we;
                logic [31:0] a, d;
                we = ec ? cpuWe : dmaWe;
                a  = ec ? cpuAddr : dmaAddr;
                d  = ec ? cpuWData : dmaWData;
                e_addr = a; e_wd = d; e_wr = we; e_rd = !we;
                if (we) begin
                    ref_mem[a[5:2]] = d;
                end else begin
                    r.due = cyc + 1 + LAT; r.owner = ed; r.data = ref_mem[a[5:2]];
                    ret_q.push_back(r);
                end
            end
        end
        g_c = ec; g_d = ed;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpuReq = req; cpuWe = we; cpuAddr = a; cpuWData = d;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        dmaReq = req; dmaWe = we; dmaAddr = a; dmaWData = d;
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; m_starve = 0;
        e_addr = 32'd0; e_wd = 32'd0; e_wr = 1'b0; e_rd = 1'b0;
        g_c = 1'b0; g_d = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dmem[i]    = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
            ref_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
        end

        // reset held with both requesters asking
        reset = 1'b0;
        set_cpu(1'b1, 1'b0, 32'h10, 32'd0);
        set_dma(1'b1, 1'b0, 32'h14, 32'd0);
        step(); step();
        reset = 1'b1;

        // single CPU read
        set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        step();
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) step();

        // CPU write, then DMA reads the same word back
        set_cpu(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        step();
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
        set_dma(1'b1, 1'b0, 32'h20, 32'd0);
        step();
        set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) step();

        // sustained contention exercises the starvation limit
        set_cpu(1'b1, 1'b0, $urandom, $urandom);
        set_dma(1'b1, 1'b0, $urandom, $urandom);
        repeat (10) begin
            step();
            if (g_c) set_cpu(1'b1, 1'b0, $urandom, $urandom);
            if (g_d) set_dma(1'b1, 1'b0, $urandom, $urandom);
        end
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) step();

        // interleaved reads C, D, C on consecutive cycles
        set_cpu(1'b1, 1'b0, 32'h4, 32'd0);
        step();
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
        set_dma(1'b1, 1'b0, 32'h8, 32'd0);
        step();
        set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        set_cpu(1'b1, 1'b0, 32'hC, 32'd0);
        step();
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (5) step();

        // reset lands while a read is in flight
        set_cpu(1'b1, 1'b0, 32'h10, 32'd0);
        step();
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        set_cpu(1'b1, 1'b0, 32'h18, 32'd0);
        set_dma(1'b1, 1'b0, 32'h1C, 32'd0);
        repeat (6) begin
            step();
            if (g_c) set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
            if (g_d) set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        end

        // randomized traffic with occasional resets
        repeat (3000) begin
            reset = ($urandom_range(0, 149) != 0);
            if (!cpuReq || g_c)
                set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom, $urandom);
            if (!dmaReq || g_d)
                set_dma($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom, $urandom);
            step();
        end
        reset = 1'b1;
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (LAT + 3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
